// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the 8N1 UART receiver.
// The receiver FSM encoding is exposed so checkers can bind to it.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_rx_state_t;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_WIDTH_DEF   = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Byte stream from the UART receiver to its consumer, plus error pulses.
// Handshake: o_data is stable while o_valid=1; a byte transfers on an enabled
// cycle with o_valid && i_out_ready, and o_valid may not drop before that.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  i_out_ready;
  logic                  o_frame_err;
  logic                  o_overrun;

  modport master (
    output o_data, o_valid, o_frame_err, o_overrun,
    input  i_out_ready
  );

  modport slave (
    input  o_data, o_valid, o_frame_err, o_overrun,
    output i_out_ready
  );
endinterface

// File: rtl/uart_rx_bit_sync.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
// Clocked every cycle; RESET_VAL sets the value both flops reset to.
module bit_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, stop-bit check, 1-deep output buffer
// feeding a valid/ready byte stream, with frame-error and overrun pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  input  logic           i_rx,
  uart_rx_if.master      out_if,
  output uart_rx_state_t o_state
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  logic rx_s;

  bit_sync #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_rx),
    .q   (rx_s)
  );

  uart_rx_state_t        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  byte_done;
  logic                  xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    byte_done   = 1'b0;
    xfer        = 1'b0;

    // Pulses hold their value on disabled cycles, so clear only when enabled.
    if (clk_en) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_d = '0;
            if (rx_s) begin
              byte_done = 1'b1;
              state_d   = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      // A transfer in the same cycle frees the slot for the completing byte.
      xfer = valid_q && out_if.i_out_ready;
      if (byte_done) begin
        if (!valid_q || xfer) begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else if (xfer) begin
        valid_d = 1'b0;
      end
    end
  end

  assign out_if.o_data      = data_q;
  assign out_if.o_valid     = valid_q;
  assign out_if.o_frame_err = frame_err_q;
  assign out_if.o_overrun   = overrun_q;
  assign o_state            = state_q;
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial 8N1 UART receiver sitting directly upstream of the boot-monitor command parser. It synchronises the raw RX pin, detects and validates start bits, samples data bits at mid-bit, checks the stop bit, and presents each received byte on a valid/ready byte stream that the parser consumes. Framing errors and overruns are reported as single-cycle pulses.

## Interface
Parameters:
- CLKS_PER_BIT, 16: enabled clock cycles per serial bit; even; minimum 4.
- DATA_WIDTH, 8: data bits per frame, sent LSB first.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high; acts regardless of clk_en.
- clk_en  input  1  clock enable; all state and counters advance only on cycles with clk_en=1.
- i_rx  input  1  asynchronous serial line; idle high.
- o_data  output  DATA_WIDTH  received byte.
- o_valid  output  1  o_data holds an unconsumed byte.
- i_out_ready  input  1  downstream accepts the byte.
- o_frame_err  output  1  one-enabled-cycle pulse: stop bit sampled low.
- o_overrun  output  1  one-enabled-cycle pulse: completed byte dropped because the buffer was full.

## Operation
- Two-flop synchroniser on i_rx, reset value 1. Both flops are clocked every clk, not gated by clk_en. All logic uses the synchronised value rx_s.
- Bit counter cnt has width $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2. Bit index idx has width $clog2(DATA_WIDTH+1).
- State machine states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_s=0, go to START with cnt=0.
  - START: when cnt=HALF-1, sample rx_s.
    - rx_s=0: go to DATA with cnt=0, idx=0.
    - rx_s=1: glitch. Return to IDLE with no output.
  - DATA: when cnt=CLKS_PER_BIT-1, shift rx_s into shift[DATA_WIDTH-1] (right shift, LSB first), set cnt=0, idx++. After the DATA_WIDTH-th sample, go to STOP.
  - STOP: when cnt=CLKS_PER_BIT-1, sample rx_s.
    - rx_s=1: byte complete. Go to IDLE.
    - rx_s=0: pulse o_frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break condition from being read as repeated frames.
  - Any undefined encoding: go to IDLE.
- Output buffer (1 deep):
  - Transfer occurs on an enabled cycle with o_valid && i_out_ready. o_valid clears the next cycle unless a new byte loads.
  - A byte completing when the buffer is empty, or in the same enabled cycle as a transfer, loads o_data and sets o_valid. No overrun in this case.
  - A byte completing while o_valid=1 and i_out_ready=0: the new byte is dropped, o_overrun pulses, and the held o_data is unchanged.
  - o_data is stable while o_valid=1.
- Reset mid-frame: the frame is abandoned, any buffered byte is lost, and the receiver resumes hunting from IDLE.

## Timing
- Reset values: o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, state=IDLE, cnt=0, idx=0, synchroniser=1.
- The start edge is seen 2 clk after the i_rx fall (synchroniser), then in IDLE on the next enabled cycle.
- Sample points, counted from entry to START:
  - start bit: HALF enabled cycles;
  - data bit k: HALF + (k+1)·CLKS_PER_BIT;
  - stop bit: HALF + (DATA_WIDTH+1)·CLKS_PER_BIT.
- o_valid rises on the enabled cycle following the stop-bit sample.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge half a bit later is caught. Tolerates ±3 % baud mismatch at CLKS_PER_BIT=16.
- o_frame_err and o_overrun are registered and high for exactly one enabled cycle. When clk_en is low they hold their value, so consumers qualify them with clk_en.

## Structure
- Add the uart_rx_state_t enum (IDLE, START, DATA, STOP, WAIT_HIGH; logic [2:0]) to types.svh, alongside the existing ASCII constants and the bios state types.
- One sub-module, bit_sync: a generic two-flop synchroniser with a reset value parameter. It is reused later for other pins.

## Test plan
All scenarios use CLKS_PER_BIT=16 and clk_en=1 unless stated.
- Frame 0x62 ('b') with i_out_ready=0 → o_valid=1, o_data=0x62, held stable; i_out_ready=1 for one cycle → o_valid=0 the next cycle.
- Low glitch of 5 cycles on an idle line → no o_valid and no o_frame_err; a following frame 0x6E is received correctly.
- Frame 0x77 with the stop bit driven low → o_frame_err pulses once and o_valid stays 0; line held low 100 cycles → no further events; line high, then frame 0x72 → received as 0x72.
- Frames 0x6E then 0x6F back-to-back with i_out_ready=0 → o_data=0x6E retained, o_overrun pulses once at the second byte's completion; then ready → 0x6E accepted.
- Byte completes in the same cycle as a transfer of the previous byte → new byte loaded, no o_overrun.
- Two further cases:
  - rst asserted mid-frame for 1 cycle → all outputs 0; next frame 0x65 received correctly.
  - clk_en high 1 cycle in 4, bit period 64 clk → 0x64 received correctly.
